// File: rtl/seg14_scan_sched.sv
// Scan scheduler for a 12-digit 14-segment display: shadow/active message buffers,
// programmable dwell, blanking and scroll; all outputs registered one cycle after the state decision.
module seg14_scan_sched #(
  parameter int DIV_W   = 16,
  parameter int MSG_LEN = 16
) (
`ifdef USE_POWER_PINS
  inout  wire              vdd,
  inout  wire              vss,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] tick_div,
  input  logic [3:0]       blank_cyc,
  input  logic             scroll_en,
  input  logic [7:0]       scroll_div,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [13:0]      wr_data,
  input  logic             commit,
  output logic             commit_pend,
  output logic             frame_done,
  output logic [11:0]      sel,
  output logic [13:0]      segm
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t           state, state_n;
  logic [3:0]       digit, digit_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [3:0]       offset, offset_n;
  logic [7:0]       scnt, scnt_n;
  logic [13:0]      shadow [MSG_LEN];
  logic [13:0]      active [MSG_LEN];
  logic             start_digit, boundary, apply;
  logic [3:0]       idx;
  logic [11:0]      sel_n;
  logic [13:0]      segm_n;
  logic             fd_n;

  always_comb begin
    state_n     = state;
    digit_n     = digit;
    cnt_n       = cnt;
    start_digit = 1'b0;
    boundary    = 1'b0;
    if (!en) begin
      state_n = IDLE;
      digit_n = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          digit_n     = '0;
          start_digit = 1'b1;
        end
        BLANK: begin
          if (cnt == '0) begin
            state_n = SHOW;
            cnt_n   = tick_div;
          end else begin
            cnt_n = cnt - DIV_W'(1);
          end
        end
        SHOW: begin
          if (cnt != '0) begin
            cnt_n = cnt - DIV_W'(1);
          end else begin
            boundary    = (digit == 4'd11);
            digit_n     = boundary ? 4'd0 : digit + 4'd1;
            start_digit = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      // Phase lengths are sampled here, at the start of each digit slot.
      if (start_digit) begin
        if (blank_cyc == 4'd0) begin
          state_n = SHOW;
          cnt_n   = tick_div;
        end else begin
          state_n = BLANK;
          cnt_n   = DIV_W'(blank_cyc - 4'd1);
        end
      end
    end

    apply    = boundary & commit_pend;
    offset_n = offset;
    scnt_n   = scroll_en ? scnt : 8'd0;
    if (apply) begin
      offset_n = '0;
      scnt_n   = '0;
    end else if (boundary && scroll_en) begin
      if (scnt == scroll_div) begin
        offset_n = offset + 4'd1;
        scnt_n   = '0;
      end else begin
        scnt_n = scnt + 8'd1;
      end
    end

    // Look ahead to the post-commit buffer so digit 0 shows new data immediately.
    idx    = offset_n + digit_n;
    sel_n  = (state_n == SHOW) ? (12'd1 << digit_n) : 12'd0;
    segm_n = (state_n == SHOW) ? (apply ? shadow[idx] : active[idx]) : 14'd0;
    fd_n   = (state_n == SHOW) && (digit_n == 4'd11) && (cnt_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      digit       <= '0;
      cnt         <= '0;
      offset      <= '0;
      scnt        <= '0;
      commit_pend <= 1'b0;
      frame_done  <= 1'b0;
      sel         <= '0;
      segm        <= '0;
    end else begin
      state       <= state_n;
      digit       <= digit_n;
      cnt         <= cnt_n;
      offset      <= offset_n;
      scnt        <= scnt_n;
      commit_pend <= commit | (commit_pend & ~apply);
      frame_done  <= fd_n;
      sel         <= sel_n;
      segm        <= segm_n;
    end
  end

  // The copy reads shadow before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (apply) begin
        for (int i = 0; i < MSG_LEN; i++) active[i] <= shadow[i];
      end
      if (wr_en) shadow[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_seg14_scan_sched.sv
// Directed bench for seg14_scan_sched: start-up, commit, blanking, scroll wrap,
// commit at the frame boundary, enable drop and asynchronous reset.
module tb_seg14_scan_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] tick_div;
  logic [3:0]  blank_cyc;
  logic        scroll_en;
  logic [7:0]  scroll_div;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [13:0] wr_data;
  logic        commit;
  logic        commit_pend;
  logic        frame_done;
  logic [11:0] sel;
  logic [13:0] segm;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg14_scan_sched #(.DIV_W(16), .MSG_LEN(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick_div   (tick_div),
    .blank_cyc  (blank_cyc),
    .scroll_en  (scroll_en),
    .scroll_div (scroll_div),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .commit_pend(commit_pend),
    .frame_done (frame_done),
    .sel        (sel),
    .segm       (segm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; en = 1'b0; tick_div = '0; blank_cyc = '0;
    scroll_en = 1'b0; scroll_div = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; commit = 1'b0;
    step(); step();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_segm", 32'(segm), 0);
    chk("rst_pend", 32'(commit_pend), 0);
    chk("rst_fd", 32'(frame_done), 0);
    rst_n = 1'b1;

    // Idle with en=0
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_sel", 32'(sel), 0);
      chk("idle_fd", 32'(frame_done), 0);
    end
    chk("idle_segm", 32'(segm), 0);
    chk("idle_pend", 32'(commit_pend), 0);

    // Load shadow[k]=k+1 and commit
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = 14'(k + 1);
      step();
    end
    wr_en = 1'b0; commit = 1'b1;
    step();
    commit = 1'b0;
    chk("pend_set", 32'(commit_pend), 1);

    en = 1'b1;
    step();
    for (int d = 0; d < 12; d++) begin
      chk($sformatf("f1_sel%0d", d), 32'(sel), 32'(1) << d);
      chk($sformatf("f1_segm%0d", d), 32'(segm), 0);
      chk($sformatf("f1_fd%0d", d), 32'(frame_done), (d == 11) ? 1 : 0);
      step();
    end
    chk("pend_clr", 32'(commit_pend), 0);
    for (int d = 0; d < 12; d++) begin
      chk($sformatf("f2_sel%0d", d), 32'(sel), 32'(1) << d);
      chk($sformatf("f2_segm%0d", d), 32'(segm), d + 1);
      chk($sformatf("f2_fd%0d", d), 32'(frame_done), (d == 11) ? 1 : 0);
      step();
    end

    // blank_cyc=2, tick_div=3: 72-cycle frames
    en = 1'b0;
    step();
    blank_cyc = 4'd2; tick_div = 16'd3; en = 1'b1;
    step();
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 12; d++)
        for (int c = 0; c < 6; c++) begin
          chk($sformatf("bl_sel f%0d d%0d c%0d", f, d, c), 32'(sel), (c < 2) ? 0 : (32'(1) << d));
          chk($sformatf("bl_segm f%0d d%0d c%0d", f, d, c), 32'(segm), (c < 2) ? 0 : d + 1);
          chk($sformatf("bl_fd f%0d d%0d c%0d", f, d, c), 32'(frame_done), (d == 11 && c == 5) ? 1 : 0);
          step();
        end

    // Scroll every 2 frames; offset 5 wraps digit 11 to entry 0
    en = 1'b0;
    step();
    blank_cyc = 4'd0; tick_div = 16'd0; scroll_en = 1'b1; scroll_div = 8'd1; en = 1'b1;
    step();
    for (int f = 0; f < 12; f++)
      for (int d = 0; d < 12; d++) begin
        chk($sformatf("sc_segm f%0d d%0d", f, d), 32'(segm), ((f / 2 + d) % 16) + 1);
        chk($sformatf("sc_sel f%0d d%0d", f, d), 32'(sel), 32'(1) << d);
        step();
      end

    // Commit coinciding with the frame boundary (offset now 6, held)
    scroll_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 14'h0111;
    step();
    wr_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("fd_seen", 32'(seen), 1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 14'h2AAA; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    chk("bnd_pend", 32'(commit_pend), 1);
    chk("bnd_old_segm", 32'(segm), 7);
    repeat (11) step();
    chk("bnd_fd", 32'(frame_done), 1);
    chk("bnd_pend2", 32'(commit_pend), 1);
    step();
    chk("bnd_pend_clr", 32'(commit_pend), 0);
    chk("bnd_new_sel", 32'(sel), 1);
    chk("bnd_new_segm", 32'(segm), 32'h2AAA);
    step();
    chk("bnd_d1_sel", 32'(sel), 2);
    chk("bnd_d1_segm", 32'(segm), 2);

    // Drop en during digit 6 then restart
    repeat (5) step();
    chk("d6_sel", 32'(sel), 32'h040);
    chk("d6_segm", 32'(segm), 7);
    en = 1'b0;
    step();
    chk("off_sel", 32'(sel), 0);
    chk("off_segm", 32'(segm), 0);
    en = 1'b1;
    step();
    chk("re_sel", 32'(sel), 1);
    chk("re_segm", 32'(segm), 32'h2AAA);
    step();
    chk("re_d1_sel", 32'(sel), 2);
    chk("re_d1_segm", 32'(segm), 2);

    // Asynchronous reset mid-frame
    rst_n = 1'b0; en = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 0);
    chk("arst_segm", 32'(segm), 0);
    chk("arst_fd", 32'(frame_done), 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("arst_pend", 32'(commit_pend), 0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    en = 1'b1;
    step();
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 12; d++) begin
        chk($sformatf("z_segm f%0d d%0d", f, d), 32'(segm), 0);
        chk($sformatf("z_sel f%0d d%0d", f, d), 32'(sel), 32'(1) << d);
        step();
      end
    chk("z_pend", 32'(commit_pend), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
